// File: rtl/hilo_unit.sv
// HI/LO register unit: latches a multi-cycle MUL/DIV result into HI/LO after a
// fixed latency, and serves MFHI/MFLO reads, stalling requests while busy.
module hilo_unit #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 12
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        op_valid,
  input  logic [2:0]  alu_op,
  input  logic [31:0] in2,
  input  logic [63:0] md_result,
  input  logic        rd_req,
  input  logic        rd_sel,
  output logic [31:0] rd_data,
  output logic        rd_valid,
  output logic        busy,
  output logic        stall,
  output logic        div_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [3:0] MUL_LOAD = 4'(MUL_LAT - 1);
  localparam logic [3:0] DIV_LOAD = 4'(DIV_LAT - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2
  } state_t;

  state_t      state_reg;
  logic [3:0]  cnt_reg;
  logic [63:0] pending_reg;

  logic is_mul, is_div, md_op, idle, accept, rd_ok;

  assign is_mul = (alu_op == OP_MUL);
  assign is_div = (alu_op == OP_DIV);
  assign md_op  = op_valid && (is_mul || is_div);
  assign idle   = (state_reg == IDLE);
  // A read always wins over a simultaneous md_op so it sees pre-op HI/LO.
  assign accept = md_op && idle && !rd_req;
  assign rd_ok  = rd_req && idle;
  assign stall  = (md_op && !accept) || (rd_req && !idle);
  assign busy   = !idle;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      pending_reg <= '0;
      hi          <= '0;
      lo          <= '0;
      rd_data     <= '0;
      rd_valid    <= 1'b0;
      div_zero    <= 1'b0;
    end else begin
      rd_valid <= rd_ok;
      if (rd_ok) begin
        rd_data <= rd_sel ? hi : lo;
      end

      case (state_reg)
        IDLE: begin
          if (accept) begin
            if (is_div && (in2 == 32'd0)) begin
              // Divide-by-zero: flag it and leave HI/LO untouched.
              div_zero <= 1'b1;
            end else begin
              div_zero    <= 1'b0;
              pending_reg <= md_result;
              cnt_reg     <= is_div ? DIV_LOAD : MUL_LOAD;
              state_reg   <= is_div ? DIV_WAIT : MUL_WAIT;
            end
          end
        end
        MUL_WAIT, DIV_WAIT: begin
          if (cnt_reg == 4'd0) begin
            hi        <= pending_reg[63:32];
            lo        <= pending_reg[31:0];
            state_reg <= IDLE;
          end else begin
            cnt_reg <= cnt_reg - 4'd1;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_unit.sv
// Scoreboard bench for hilo_unit: timestamp-based reference model, read
// expectations queued by the driver and popped by a separate monitor.
module tb_hilo_unit;

  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 12;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [2:0]  alu_op = 3'd0;
  logic [31:0] in2 = 32'd0;
  logic [63:0] md_result = 64'd0;
  logic        rd_req = 1'b0;
  logic        rd_sel = 1'b0;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        busy;
  logic        stall;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  hilo_unit #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .alu_op(alu_op),
    .in2(in2), .md_result(md_result), .rd_req(rd_req), .rd_sel(rd_sel),
    .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .stall(stall),
    .div_zero(div_zero), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a pending result lands on an absolute edge number.
  int          edge_cnt = 0;
  logic        m_busy = 1'b0;
  int          m_done = 0;
  logic [63:0] m_pending = 64'd0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  logic        m_dz = 1'b0;
  logic [31:0] rd_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Monitor: every rd_valid pulse must match the oldest queued read.
  always @(negedge clk) begin
    if (rst_n && rd_valid) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got rd_valid data %h, expected no read", rd_data);
      end else begin
        logic [31:0] e;
        e = rd_q.pop_front();
        if (rd_data !== e) begin
          errors++;
          $display("FAIL rd_data: got %h expected %h", rd_data, e);
        end else begin
          $display("read ok: %h", rd_data);
        end
      end
    end
  end

  // One clock cycle: check state, drive inputs, check stall, advance model.
  task automatic step(input logic ov, input logic [2:0] op, input logic [31:0] d,
                      input logic [63:0] res, input logic rr, input logic sel);
    logic md, exp_stall;
    chk("busy", busy, m_busy);
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    chk("div_zero", div_zero, m_dz);
    op_valid = ov; alu_op = op; in2 = d; md_result = res; rd_req = rr; rd_sel = sel;
    #1;
    md = ov && (op == 3'b010 || op == 3'b011);
    exp_stall = m_busy ? (md || rr) : (md && rr);
    chk("stall", stall, exp_stall);
    if (m_busy) begin
      if (edge_cnt + 1 == m_done) begin
        m_hi = m_pending[63:32];
        m_lo = m_pending[31:0];
        m_busy = 1'b0;
      end
    end else if (rr) begin
      rd_q.push_back(sel ? m_hi : m_lo);
    end else if (md) begin
      if (op == 3'b011 && d == 32'd0) begin
        m_dz = 1'b1;
      end else begin
        m_dz = 1'b0;
        m_pending = res;
        m_busy = 1'b1;
        m_done = edge_cnt + 1 + ((op == 3'b011) ? DIV_LAT : MUL_LAT);
      end
    end
    @(posedge clk);
    edge_cnt++;
    #1;
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 32'd1, 64'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    op_valid = 1'b0; rd_req = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("rst_hi", hi, 32'd0);
    chk("rst_lo", lo, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_rd_valid", rd_valid, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_div_zero", div_zero, 1'b0);
    m_busy = 1'b0; m_hi = '0; m_lo = '0; m_dz = 1'b0; m_pending = '0;
    rd_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    edge_cnt++;
    #1;
  endtask

  initial begin
    @(posedge clk);
    #1;
    do_reset();

    // MUL with known result, then read HI back.
    step(1'b1, 3'b010, 32'd5, 64'h0000_0001_0000_0002, 1'b0, 1'b0);
    idle_n(MUL_LAT);
    step(1'b0, 3'd0, 32'd0, 64'd0, 1'b1, 1'b1);
    idle_n(2);

    // Divide by zero sets the flag; a MUL clears it.
    step(1'b1, 3'b011, 32'd0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0);
    idle_n(1);
    step(1'b1, 3'b010, 32'd0, 64'h1111_2222_3333_4444, 1'b0, 1'b0);
    idle_n(MUL_LAT + 1);

    // DIV with a read held through the whole wait.
    step(1'b1, 3'b011, 32'd7, 64'h0000_00AA_0000_00BB, 1'b0, 1'b0);
    for (int i = 0; i < DIV_LAT + 1; i++) step(1'b0, 3'd0, 32'd0, 64'd0, 1'b1, 1'b0);
    idle_n(2);

    // Second MUL while DIV in flight must be dropped.
    step(1'b1, 3'b011, 32'd3, 64'h5555_0000_6666_0000, 1'b0, 1'b0);
    step(1'b1, 3'b010, 32'd3, 64'h9999_9999_9999_9999, 1'b0, 1'b0);
    idle_n(DIV_LAT + 1);

    // Read and md_op in the same IDLE cycle: old LO returned, op accepted next.
    step(1'b1, 3'b010, 32'd1, 64'h0000_0000_DEAD_BEEF, 1'b0, 1'b0);
    idle_n(MUL_LAT);
    step(1'b1, 3'b010, 32'd1, 64'h1234_5678_9ABC_DEF0, 1'b1, 1'b0);
    step(1'b1, 3'b010, 32'd1, 64'h1234_5678_9ABC_DEF0, 1'b0, 1'b0);
    idle_n(MUL_LAT + 1);

    // Reset in the middle of DIV_WAIT discards the result.
    step(1'b1, 3'b011, 32'd9, 64'hCAFE_CAFE_F00D_F00D, 1'b0, 1'b0);
    idle_n(4);
    do_reset();
    idle_n(DIV_LAT + 2);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      logic ov, rr, sel;
      logic [2:0] op;
      logic [31:0] d;
      ov  = ($urandom_range(0, 2) == 0);
      op  = ($urandom_range(0, 3) != 0) ? 3'(2 + $urandom_range(0, 1)) : 3'($urandom_range(0, 7));
      d   = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
      rr  = ($urandom_range(0, 3) == 0);
      sel = 1'($urandom_range(0, 1));
      step(ov, op, d, {$urandom, $urandom}, rr, sel);
    end
    idle_n(DIV_LAT + 2);

    chk("rd_queue_empty", 64'(rd_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/hilo_unit.md
HILO_UNIT -- requirements
Module: hilo_unit

Interface
REQ-001 Parameter MUL_LAT, default 4: cycles from MUL acceptance to HI/LO update; legal range 1..15.
REQ-002 Parameter DIV_LAT, default 12: cycles from DIV acceptance to HI/LO update; legal range 1..15.
REQ-003 clk  in  1  single clock; all state SHALL change on its rising edge only.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 op_valid  in  1  EX-stage issue strobe for the current alu_op.
REQ-006 alu_op  in  3  ALU operation code: 3'b010 = MUL, 3'b011 = DIV; all other codes are ignored by this block.
REQ-007 in2  in  32  divisor operand, used only for divide-by-zero detection.
REQ-008 md_result  in  64  ALU 64-bit multiply/divide result, valid in the issue cycle.
REQ-009 rd_req  in  1  MFHI/MFLO read request.
REQ-010 rd_sel  in  1  read select: 0 = LO, 1 = HI.
REQ-011 rd_data  out  32  registered read data.
REQ-012 rd_valid  out  1  one-cycle pulse qualifying rd_data.
REQ-013 busy  out  1  a MUL/DIV is in flight.
REQ-014 stall  out  1  combinational: the current request is not accepted this cycle.
REQ-015 div_zero  out  1  sticky flag: the last accepted DIV had in2 == 0.
REQ-016 hi  out  32  architectural HI register.
REQ-017 lo  out  32  architectural LO register.

Function
REQ-018 States SHALL be IDLE, MUL_WAIT and DIV_WAIT; busy = 1 exactly when the state is not IDLE.
REQ-019 md_op SHALL be defined as op_valid AND (alu_op == MUL or alu_op == DIV).
REQ-020 Acceptance conditions for md_op:
- accepted only in IDLE with rd_req = 0;
- on acceptance: md_result is captured into a 64-bit pending register, the counter is loaded with LAT-1, and the state moves to MUL_WAIT or DIV_WAIT;
- div_zero is cleared.
REQ-021 In a WAIT state, each rising edge:
- if counter == 0: hi <= pending[63:32], lo <= pending[31:0], state -> IDLE;
- otherwise the counter decrements.
REQ-022 Consequence of REQ-021: busy SHALL be high for exactly LAT cycles, and hi/lo SHALL change on the LAT-th rising edge after the acceptance edge.
REQ-023 Accepted DIV with in2 == 0:
- state stays IDLE, no pending capture;
- hi/lo are unchanged;
- div_zero is set on the acceptance edge.
REQ-024 md_op while busy: stall = 1; the op is not captured; pending and the counter are unaffected.
REQ-025 rd_req in IDLE: on the next edge, rd_data <= (rd_sel ? hi : lo) and rd_valid <= 1; rd_valid SHALL be 0 in every other cycle.
REQ-026 rd_req while busy: stall = 1 and no read is performed; this prevents stale HI/LO reads.
REQ-027 rd_req and md_op together in IDLE: the read is served and returns the pre-op hi/lo; the md_op is stalled (stall = 1).
REQ-028 rd_req in the completion cycle (counter == 0) SHALL be stalled; the read is served on the following cycle and returns the new value.
REQ-029 md_op in the completion cycle SHALL be stalled; back-to-back acceptance is possible one cycle after completion.
REQ-030 Non-MUL/DIV alu_op values and op_valid = 0 SHALL have no effect on any state.
REQ-031 The counter SHALL never wrap; it is only decremented when non-zero.

Reset
REQ-032 rst_n low SHALL immediately force:
- state = IDLE, counter = 0, pending = 0;
- hi = lo = rd_data = 0;
- rd_valid = busy = div_zero = 0.
REQ-033 Reset asserted mid-operation SHALL discard the in-flight result; hi/lo never receive it.
REQ-034 After rst_n deasserts, the block SHALL accept md_op on the first rising edge.

Verification
REQ-035 MUL accepted with md_result = 64'h0000_0001_0000_0002 -> busy high for 4 cycles; hi = 1 and lo = 2 after edge 4; rd_sel = 1 read then returns 32'h1 with a single rd_valid pulse.
REQ-036 DIV accepted with in2 = 0 -> div_zero = 1, busy stays 0, hi/lo unchanged; a following MUL accept clears div_zero.
REQ-037 DIV accepted, then rd_req held from cycle 1 -> stall = 1 for cycles 1..12; rd_valid in cycle 13 returns the new lo.
REQ-038 Second MUL issued while DIV_WAIT -> stall = 1, no capture; hi/lo reflect only the DIV result.
REQ-039 rd_req and md_op in the same IDLE cycle -> read returns the old value (e.g. lo = 32'hDEAD_BEEF); md_op stalled one cycle, then accepted.
REQ-040 rst_n pulsed low at cycle 5 of DIV_WAIT -> all outputs 0 immediately; no later hi/lo update occurs.
